// File: rtl/ljpeg_reconstruct_stage.sv
// ljpeg_reconstruct_stage
// Rebuilds lossless-JPEG pixels from decoded differences, one beat of
// PIXELS_PER_BEAT pixels per accepted cycle. Row 0 of a frame is predicted
// horizontally from the same-colour Bayer neighbour two positions to the left.
// Later rows are predicted from the pixel directly above, which is held in a
// one-row cache of rebuilt beats.
//
// Handshake: a beat is accepted on every rising edge where input_valid is 1.
// There is no ready signal, so the upstream decoder can never be stalled.
// output_valid pulses for exactly one cycle per accepted beat, one edge later.
// While input_valid is 0, all state (beat counter, row mode, left pair,
// cache, pixels_output) holds its value.
module ljpeg_reconstruct_stage #(
    parameter int PIXEL_BITS      = 12,
    parameter int DIFF_BITS       = 16,
    parameter int PIXELS_PER_BEAT = 16,
    parameter int BEATS_PER_ROW   = 32
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic [DIFF_BITS*PIXELS_PER_BEAT-1:0]  diffs_input,
    input  logic                                  input_valid,
    input  logic                                  frame_start,
    output logic [PIXEL_BITS*PIXELS_PER_BEAT-1:0] pixels_output,
    output logic                                  output_valid,
    output logic                                  new_row,
    output logic                                  multi_row_mode
);

    localparam int BEAT_W = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int EXT_W  = (DIFF_BITS > PIXEL_BITS) ? DIFF_BITS : PIXEL_BITS;
    localparam int ROW_W  = PIXEL_BITS * PIXELS_PER_BEAT;
    localparam int PAIR_W = 2 * PIXEL_BITS;

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS_PER_ROW - 1);
    localparam logic [PIXEL_BITS-1:0] MID_GREY  = {1'b1, {(PIXEL_BITS-1){1'b0}}};

    logic [BEAT_W-1:0]     beat_cnt;
    logic [PAIR_W-1:0]     left_pair;
    logic [ROW_W-1:0]      row_cache [BEATS_PER_ROW];

    logic [BEAT_W-1:0]     eff_beat;
    logic                  eff_multi;
    logic [ROW_W-1:0]      above_row;
    logic [ROW_W-1:0]      rebuilt_row;
    logic [PIXEL_BITS-1:0] pred    [PIXELS_PER_BEAT];
    logic [PIXEL_BITS-1:0] rebuilt [PIXELS_PER_BEAT];
    logic [EXT_W-1:0]      sum_ext;

    // A frame_start beat is always row 0, beat 0, regardless of the counters.
    assign eff_beat  = frame_start ? '0 : beat_cnt;
    assign eff_multi = multi_row_mode & ~frame_start;

    // Cache read sees the previous row even when the same slot is written this edge.
    assign above_row = row_cache[eff_beat];

    // Prediction and modular reconstruction; row 0 chains element i-2 -> i.
    always_comb begin
        sum_ext     = '0;
        rebuilt_row = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            pred[i]    = '0;
            rebuilt[i] = '0;
        end
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            if (eff_multi) begin
                pred[i] = above_row[i*PIXEL_BITS +: PIXEL_BITS];
            end else if (i >= 2) begin
                pred[i] = rebuilt[(i >= 2) ? i - 2 : 0];
            end else if (eff_beat == '0) begin
                pred[i] = MID_GREY;
            end else begin
                pred[i] = left_pair[(i % 2)*PIXEL_BITS +: PIXEL_BITS];
            end
            sum_ext    = EXT_W'(pred[i]) + EXT_W'($signed(diffs_input[i*DIFF_BITS +: DIFF_BITS]));
            rebuilt[i] = sum_ext[PIXEL_BITS-1:0];
            rebuilt_row[i*PIXEL_BITS +: PIXEL_BITS] = rebuilt[i];
        end
    end

    // Row cache write: every accepted beat overwrites its column slot.
    always_ff @(posedge sys_clk) begin
        if (input_valid) begin
            row_cache[eff_beat] <= rebuilt_row;
        end
    end

    // Beat/row tracking, left-pair history and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pixels_output  <= '0;
            output_valid   <= 1'b0;
            new_row        <= 1'b0;
            multi_row_mode <= 1'b0;
            beat_cnt       <= '0;
            left_pair      <= '0;
        end else begin
            output_valid <= input_valid;
            new_row      <= input_valid && (eff_beat == '0);
            if (input_valid) begin
                pixels_output  <= rebuilt_row;
                left_pair      <= rebuilt_row[ROW_W-1 -: PAIR_W];
                beat_cnt       <= eff_beat + BEAT_W'(1);
                multi_row_mode <= (eff_beat == LAST_BEAT) ? 1'b1 : eff_multi;
            end
        end
    end

endmodule
